mini_calc_seq: RTL and testbench
================================

MINI_CALC_SEQ -- requirements
Module: mini_calc_seq

Interface
REQ-001 Parameter INPUT_BIT_WIDTH, default 8, SHALL set operand and per-output result width W (W >= 2).
REQ-002 Parameter INSTR_BIT_WIDTH, default 4, SHALL set instruction width.
REQ-003 Parameters CODE_INSTR_NOP=4'b1111, CODE_INSTR_ADD_SUB=4'b0111, CODE_INSTR_MIN_MAX=4'b1011, CODE_INSTR_MUL=4'b1101, CODE_INSTR_DIV=4'b1110 SHALL define the opcodes; any other code is PASS.
REQ-004 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 RstN  input  1  reset, asynchronous, active-low.
REQ-006 InValid  input  1  request present.
REQ-007 InReady  output  1  block can accept a request.
REQ-008 Instruction  input  INSTR_BIT_WIDTH  opcode, sampled on acceptance.
REQ-009 InputA, InputB  input  W each  operands, sampled on acceptance.
REQ-010 OutValid  output  1  result present.
REQ-011 OutReady  input  1  consumer takes result.
REQ-012 OutputA, OutputB  output  W each  registered results.
REQ-013 DivByZero  output  1  set with a DIV result whose divisor was 0.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, DONE; InReady SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL occur in a cycle with InValid=1 and InReady=1; operands and opcode are latched, and later input changes have no effect.
REQ-016 Single-cycle ops (NOP, ADD_SUB, MIN_MAX, PASS, DIV by zero) SHALL go IDLE->DONE with OutValid=1 in the cycle after acceptance.
REQ-017 ADD_SUB: OutputA=(A+B) mod 2^W, OutputB=(A-B) mod 2^W, both unsigned.
REQ-018 MIN_MAX: OutputA=max(A,B), OutputB=min(A,B), unsigned; for A==B both equal A.
REQ-019 NOP: both outputs 0. PASS: OutputA=A, OutputB=B.
REQ-020 MUL: iterative shift-add, one multiplier bit per cycle; after exactly W cycles in MUL, go to DONE with {OutputB,OutputA}=A*B (2W-bit unsigned product); OutValid asserts W+1 cycles after acceptance.
REQ-021 DIV, B!=0: restoring division, one quotient bit per cycle; after exactly W cycles in DIV, go to DONE with OutputA=A/B and OutputB=A%B; OutValid asserts W+1 cycles after acceptance.
REQ-022 DIV, B==0: OutputA=all ones, OutputB=A, DivByZero=1, single-cycle latency.
REQ-023 DivByZero SHALL be 0 for every result other than REQ-022.
REQ-024 In DONE, OutValid=1 and OutputA, OutputB, DivByZero SHALL hold stable until a cycle with OutReady=1; the next state is then IDLE.
REQ-025 A new request SHALL NOT be accepted in the same cycle a result is consumed; minimum issue interval is 2 cycles.
REQ-026 Outside DONE, OutValid=0; output registers hold their last value.
REQ-027 The iteration counter SHALL be ceil(log2(W+1)) bits and SHALL NOT wrap before reaching W.

Reset
REQ-028 RstN=0 SHALL immediately force IDLE, InReady=1 (once released), OutValid=0, OutputA=0, OutputB=0, DivByZero=0, and clear the counter and internal accumulators.
REQ-029 Reset asserted mid-MUL or mid-DIV SHALL abandon the operation with no result emitted.

Configuration
REQ-030 Macro MINI_CALC_SEQ_MUL_EN defined: MUL behaves per REQ-020.
REQ-031 Macro MINI_CALC_SEQ_MUL_EN undefined: the MUL state and its datapath are absent; CODE_INSTR_MUL completes in one cycle with both outputs 0 and DivByZero=0.

Verification (W=8)
REQ-032 ADD_SUB A=200 B=100 accepted at cycle N -> OutValid at N+1, OutputA=44, OutputB=100.
REQ-033 MUL A=255 B=255 at N -> OutValid at N+9, OutputB=0xFE, OutputA=0x01; without macro, OutValid at N+1 with outputs 0.
REQ-034 DIV A=200 B=7 at N -> OutValid at N+9, OutputA=28, OutputB=4, DivByZero=0.
REQ-035 DIV A=13 B=0 -> OutValid at N+1, OutputA=0xFF, OutputB=13, DivByZero=1; following MIN_MAX A=3 B=9 -> 9/3, DivByZero=0.
REQ-036 MIN_MAX result with OutReady held 0 for 5 cycles, InValid=1 throughout -> outputs stable, InReady=0; consumed on the 6th cycle; next request accepted no earlier than the following cycle.
REQ-037 RstN pulsed low during cycle 4 of DIV A=200 B=7 -> OutValid never asserts for it; outputs 0; InReady=1 after release.

Source files
------------

// File: rtl/mini_calc_seq.sv
// Sequential mini calculator: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Optional feature macro: MINI_CALC_SEQ_MUL_EN enables the iterative multiplier (MUL state and datapath).
module mini_calc_seq #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int INSTR_BIT_WIDTH = 4,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP     = 4'b1111,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_ADD_SUB = 4'b0111,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_MIN_MAX = 4'b1011,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_MUL     = 4'b1101,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_DIV     = 4'b1110
) (
    input  logic                       Clk,
    input  logic                       RstN,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [INSTR_BIT_WIDTH-1:0] Instruction,
    input  logic [INPUT_BIT_WIDTH-1:0] InputA,
    input  logic [INPUT_BIT_WIDTH-1:0] InputB,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [INPUT_BIT_WIDTH-1:0] OutputA,
    output logic [INPUT_BIT_WIDTH-1:0] OutputB,
    output logic                       DivByZero
);

    localparam int W  = INPUT_BIT_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

`ifdef MINI_CALC_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
`else
    typedef enum logic [1:0] {IDLE, DIV, DONE} stateT;
`endif

    stateT state, nextState;

    // accHi/accLo are shared: product high/low halves in MUL, remainder/quotient in DIV
    logic [W-1:0]  accHi;
    logic [W-1:0]  accLo;
    logic [W-1:0]  operand;
    logic [CW-1:0] iterCnt;

    logic          startMul, startDiv, loadOut;
    logic [W-1:0]  resA, resB;
    logic          resDbz;

`ifdef MINI_CALC_SEQ_MUL_EN
    logic [W:0]    mulSum;
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
`endif

    // Trial subtraction; sign bit of trial is the borrow that decides the quotient bit
    logic [W:0]    divShift;
    logic [W:0]    divTrial;
    logic          divGe;
    assign divShift = {accHi, accLo[W-1]};
    assign divTrial = divShift - {1'b0, operand};
    assign divGe    = ~divTrial[W];

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        startMul  = 1'b0;
        startDiv  = 1'b0;
        loadOut   = 1'b0;
        resA      = '0;
        resB      = '0;
        resDbz    = 1'b0;
        case (state)
            IDLE: begin
                if (InValid) begin
                    nextState = DONE;
                    loadOut   = 1'b1;
                    case (Instruction)
                        CODE_INSTR_NOP: begin
                            resA = '0;
                            resB = '0;
                        end
                        CODE_INSTR_ADD_SUB: begin
                            resA = InputA + InputB;
                            resB = InputA - InputB;
                        end
                        CODE_INSTR_MIN_MAX: begin
                            resA = (InputA >= InputB) ? InputA : InputB;
                            resB = (InputA >= InputB) ? InputB : InputA;
                        end
                        CODE_INSTR_MUL: begin
`ifdef MINI_CALC_SEQ_MUL_EN
                            loadOut   = 1'b0;
                            startMul  = 1'b1;
                            nextState = MUL;
`endif
                        end
                        CODE_INSTR_DIV: begin
                            if (InputB == '0) begin
                                resA   = '1;
                                resB   = InputA;
                                resDbz = 1'b1;
                            end else begin
                                loadOut   = 1'b0;
                                startDiv  = 1'b1;
                                nextState = DIV;
                            end
                        end
                        default: begin
                            resA = InputA;
                            resB = InputB;
                        end
                    endcase
                end
            end
`ifdef MINI_CALC_SEQ_MUL_EN
            MUL: begin
                if (iterCnt == LAST_ITER) begin
                    nextState = DONE;
                    loadOut   = 1'b1;
                    resA      = {mulSum[0], accLo[W-1:1]};
                    resB      = mulSum[W:1];
                end
            end
`endif
            DIV: begin
                if (iterCnt == LAST_ITER) begin
                    nextState = DONE;
                    loadOut   = 1'b1;
                    resA      = {accLo[W-2:0], divGe};
                    resB      = divGe ? divTrial[W-1:0] : divShift[W-1:0];
                end
            end
            DONE: begin
                if (OutReady) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            accHi     <= '0;
            accLo     <= '0;
            operand   <= '0;
            iterCnt   <= '0;
            OutputA   <= '0;
            OutputB   <= '0;
            DivByZero <= 1'b0;
        end else begin
            if (startMul) begin
                accHi   <= '0;
                accLo   <= InputB;
                operand <= InputA;
                iterCnt <= '0;
            end else if (startDiv) begin
                accHi   <= '0;
                accLo   <= InputA;
                operand <= InputB;
                iterCnt <= '0;
`ifdef MINI_CALC_SEQ_MUL_EN
            end else if (state == MUL) begin
                accHi   <= mulSum[W:1];
                accLo   <= {mulSum[0], accLo[W-1:1]};
                iterCnt <= iterCnt + CW'(1);
`endif
            end else if (state == DIV) begin
                accHi   <= divGe ? divTrial[W-1:0] : divShift[W-1:0];
                accLo   <= {accLo[W-2:0], divGe};
                iterCnt <= iterCnt + CW'(1);
            end
            if (loadOut) begin
                OutputA   <= resA;
                OutputB   <= resB;
                DivByZero <= resDbz;
            end
        end
    end

endmodule

// File: tb/tb_mini_calc_seq.sv
// Randomized self-checking bench for mini_calc_seq (W=8) against an arithmetic reference model.
module tb_mini_calc_seq;

    localparam logic [3:0] OP_NOP  = 4'b1111;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_MM   = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_DIV  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b0000;

    logic       Clk = 1'b0;
    logic       RstN = 1'b0;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [3:0] Instruction = '0;
    logic [7:0] InputA = '0;
    logic [7:0] InputB = '0;
    logic       OutValid;
    logic       OutReady = 1'b0;
    logic [7:0] OutputA;
    logic [7:0] OutputB;
    logic       DivByZero;

    int nChecks = 0;
    int nFails  = 0;

    mini_calc_seq dut (
        .Clk(Clk), .RstN(RstN), .InValid(InValid), .InReady(InReady),
        .Instruction(Instruction), .InputA(InputA), .InputB(InputB),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutputA(OutputA), .OutputB(OutputB), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: results from plain integer arithmetic, latency in cycles after acceptance
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] ea, output logic [7:0] eb, output logic ed,
                         output int lat);
        int ia, ib, p;
        ia = int'(a);
        ib = int'(b);
        ed = 1'b0;
        lat = 1;
        case (op)
            OP_NOP: begin ea = 8'd0; eb = 8'd0; end
            OP_ADD: begin ea = 8'((ia + ib) % 256); eb = 8'((ia - ib + 256) % 256); end
            OP_MM:  begin ea = 8'((ia > ib) ? ia : ib); eb = 8'((ia < ib) ? ia : ib); end
            OP_MUL: begin
`ifdef MINI_CALC_SEQ_MUL_EN
                p = ia * ib;
                ea = 8'(p % 256);
                eb = 8'(p / 256);
                lat = 9;
`else
                p = 0;
                ea = 8'(p);
                eb = 8'd0;
`endif
            end
            OP_DIV: begin
                if (ib == 0) begin
                    ea = 8'hFF; eb = a; ed = 1'b1;
                end else begin
                    ea = 8'(ia / ib); eb = 8'(ia % ib); lat = 9;
                end
            end
            default: begin ea = a; eb = b; end
        endcase
    endtask

    task automatic runOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input logic keepValid);
        logic [7:0] ea, eb;
        logic ed;
        int lat, k;
        bit found;
        model(op, a, b, ea, eb, ed, lat);
        @(negedge Clk);
        InValid = 1'b1; Instruction = op; InputA = a; InputB = b; OutReady = 1'b0;
        check("inReadyIdle", 32'(InReady), 1);
        @(posedge Clk);
        #1;
        InValid = keepValid;
        Instruction = 4'($urandom);
        InputA = 8'($urandom);
        InputB = 8'($urandom);
        k = 0;
        found = 0;
        while (!found && k < 40) begin
            @(negedge Clk);
            k++;
            if (OutValid) found = 1;
        end
        check("latency", 32'(k), 32'(lat));
        repeat (hold) begin
            check("holdValid", 32'(OutValid), 1);
            check("holdReady", 32'(InReady), 0);
            check("holdA", 32'(OutputA), 32'(ea));
            check("holdB", 32'(OutputB), 32'(eb));
            @(negedge Clk);
        end
        check("outA", 32'(OutputA), 32'(ea));
        check("outB", 32'(OutputB), 32'(eb));
        check("divByZero", 32'(DivByZero), 32'(ed));
        check("consumeReady", 32'(InReady), 0);
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        InValid = 1'b0;
        check("afterValid", 32'(OutValid), 0);
        check("afterReady", 32'(InReady), 1);
    endtask

    initial begin
        logic [3:0] codes [6];
        int cnt;
        codes[0] = OP_NOP; codes[1] = OP_ADD; codes[2] = OP_MM;
        codes[3] = OP_MUL; codes[4] = OP_DIV; codes[5] = OP_PASS;

        #1;
        check("rstValid", 32'(OutValid), 0);
        check("rstA", 32'(OutputA), 0);
        check("rstB", 32'(OutputB), 0);
        check("rstDbz", 32'(DivByZero), 0);
        repeat (2) @(negedge Clk);
        RstN = 1'b1;
        check("rstReady", 32'(InReady), 1);

        runOp(OP_ADD, 8'd200, 8'd100, 0, 1'b0);
        runOp(OP_MUL, 8'd255, 8'd255, 0, 1'b0);
        runOp(OP_DIV, 8'd200, 8'd7,   0, 1'b0);
        runOp(OP_DIV, 8'd13,  8'd0,   0, 1'b0);
        runOp(OP_MM,  8'd3,   8'd9,   0, 1'b0);
        runOp(OP_MM,  8'd77,  8'd12,  5, 1'b1);
        runOp(OP_MM,  8'd42,  8'd42,  1, 1'b0);
        runOp(OP_NOP, 8'd5,   8'd6,   0, 1'b0);
        runOp(OP_PASS, 8'd11, 8'd22,  0, 1'b0);
        runOp(OP_ADD, 8'd3,   8'd5,   2, 1'b1);
        runOp(OP_DIV, 8'd255, 8'd1,   0, 1'b0);
        runOp(OP_DIV, 8'd5,   8'd200, 0, 1'b0);

        // Reset in the 4th DIV cycle abandons the operation
        @(negedge Clk);
        InValid = 1'b1; Instruction = OP_DIV; InputA = 8'd200; InputB = 8'd7;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        repeat (4) @(negedge Clk);
        RstN = 1'b0;
        #1;
        check("midRstValid", 32'(OutValid), 0);
        check("midRstA", 32'(OutputA), 0);
        check("midRstB", 32'(OutputB), 0);
        check("midRstDbz", 32'(DivByZero), 0);
        @(negedge Clk);
        RstN = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge Clk);
            if (OutValid) cnt++;
        end
        check("midRstNoResult", 32'(cnt), 0);
        check("midRstReady", 32'(InReady), 1);
        check("midRstHoldA", 32'(OutputA), 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            if ($urandom_range(0, 5) == 0) op = 4'($urandom);
            else op = codes[$urandom_range(0, 5)];
            a = 8'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            runOp(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
